// File: rtl/keccak_rnd_seq.sv
// keccak_rnd_seq: Keccak round index and phase sequencer (single-cycle rounds, or masked
// two-share rounds with an entropy handshake). Define KECCAK_RND_SEQ_FSM_ERR_EN to trap
// unencoded FSM values in a terminal ERROR state that drives err_o.
module keccak_rnd_seq #(
    parameter  int Width     = 1600,
    parameter  int EnMasking = 0,
    localparam int W         = Width / 25,
    localparam int L         = $clog2(W),
    localparam int MaxRound  = 12 + 2 * L,
    localparam int RndW      = $clog2(MaxRound + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            clear_i,
    input  logic            rand_ack_i,
    output logic [RndW-1:0] rnd_o,
    output logic            sel_o,
    output logic            rand_valid_o,
    output logic            rand_req_o,
    output logic            state_en_o,
    output logic            busy_o,
    output logic            done_o
`ifdef KECCAK_RND_SEQ_FSM_ERR_EN
    ,
    output logic            err_o
`endif
);

    // Sparse codes, every pair at least three bits apart, so a single upset never
    // lands on another legal state.
    localparam logic [5:0] StIdle = 6'b000000;
    localparam logic [5:0] StRun  = 6'b000111;
    localparam logic [5:0] StPh1  = 6'b011001;
    localparam logic [5:0] StPh2a = 6'b101010;
    localparam logic [5:0] StPh2b = 6'b110100;
    localparam logic [5:0] StDone = 6'b101101;
`ifdef KECCAK_RND_SEQ_FSM_ERR_EN
    localparam logic [5:0] StErr  = 6'b110011;
`endif

    logic [5:0]      state_q, state_d;
    logic [RndW-1:0] rnd_q, rnd_d;
    logic            last;
    logic            active;

    assign last   = rnd_q == RndW'(MaxRound - 1);
    assign active = state_q inside {StRun, StPh1, StPh2a, StPh2b};

    // state and round index registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
        end
    end

    // next state; clear wins over every other input except a trapped error
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  state_d = start_i ? ((EnMasking != 0) ? StPh1 : StRun) : StIdle;
            StRun:   state_d = last ? StDone : StRun;
            StPh1:   state_d = StPh2a;
            StPh2a:  state_d = rand_ack_i ? StPh2b : StPh2a;
            StPh2b:  state_d = last ? StDone : StPh1;
            StDone:  state_d = StIdle;
`ifdef KECCAK_RND_SEQ_FSM_ERR_EN
            StErr:   state_d = StErr;
            default: state_d = StErr;
`else
            default: state_d = StIdle;
`endif
        endcase
`ifdef KECCAK_RND_SEQ_FSM_ERR_EN
        if (clear_i && state_d != StErr) state_d = StIdle;
`else
        if (clear_i) state_d = StIdle;
`endif
    end

    // round index: zero outside a permutation, steps after each finished round, holds on the last
    always_comb begin
        rnd_d = (clear_i || !active) ? '0 : rnd_q;
        if (!clear_i && (state_q == StRun || state_q == StPh2b) && !last) rnd_d = rnd_q + 1'b1;
    end

    // outputs decoded from the current state; unencoded values and ERROR drive everything low
    always_comb begin
        rnd_o        = rnd_q;
        sel_o        = state_q == StPh2a || state_q == StPh2b;
        state_en_o   = state_q == StRun || state_q == StPh1 || state_q == StPh2b;
        rand_req_o   = state_q == StPh2a;
        rand_valid_o = state_q == StPh2a && rand_ack_i;
        busy_o       = active || state_q == StDone;
        done_o       = state_q == StDone;
`ifdef KECCAK_RND_SEQ_FSM_ERR_EN
        err_o        = state_q == StErr;
`endif
    end

endmodule

// File: tb/tb_keccak_rnd_seq.sv
// tb_keccak_rnd_seq: randomized self-checking bench for keccak_rnd_seq, plain and masked instances
module tb_keccak_rnd_seq;

    localparam int MaxRound = 24;

    logic       clk, rst_n, start0, start1, clear, ack;
    logic [4:0] rnd0, rnd1;
    logic       sel0, rv0, rq0, en0, busy0, done0;
    logic       sel1, rv1, rq1, en1, busy1, done1;
`ifdef KECCAK_RND_SEQ_FSM_ERR_EN
    logic       err0, err1;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [10:0] tr[$];
    logic [10:0] tm[$];
    bit          ack_seq[$];

    keccak_rnd_seq #(.Width(1600), .EnMasking(0)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .clear_i(clear), .rand_ack_i(ack),
        .rnd_o(rnd0), .sel_o(sel0), .rand_valid_o(rv0), .rand_req_o(rq0),
        .state_en_o(en0), .busy_o(busy0), .done_o(done0)
`ifdef KECCAK_RND_SEQ_FSM_ERR_EN
        , .err_o(err0)
`endif
    );

    keccak_rnd_seq #(.Width(1600), .EnMasking(1)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .clear_i(clear), .rand_ack_i(ack),
        .rnd_o(rnd1), .sel_o(sel1), .rand_valid_o(rv1), .rand_req_o(rq1),
        .state_en_o(en1), .busy_o(busy1), .done_o(done1)
`ifdef KECCAK_RND_SEQ_FSM_ERR_EN
        , .err_o(err1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // observed outputs packed as {busy, done, state_en, sel, rand_req, rand_valid, rnd}
    function automatic logic [10:0] obs(input bit m);
        return m ? {busy1, done1, en1, sel1, rq1, rv1, rnd1}
                 : {busy0, done0, en0, sel0, rq0, rv0, rnd0};
    endfunction

    function automatic bit ack_at(input int c);
        return (c < ack_seq.size()) ? ack_seq[c] : 1'b1;
    endfunction

    // reference trace of one permutation from the round rules and the planned entropy pattern
    task automatic build_trace(input bit m);
        int c = 0;
        tr.delete();
        tm.delete();
        for (int r = 0; r < MaxRound; r++) begin
            if (!m) begin
                tr.push_back({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'(r)});
                tm.push_back(11'h7ff);
            end else begin
                tr.push_back({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'(r)});
                tm.push_back(11'h7ff);
                c++;
                while (!ack_at(c)) begin
                    tr.push_back({1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'(r)});
                    tm.push_back(11'h7ff);
                    c++;
                end
                tr.push_back({1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'(r)});
                tm.push_back(11'h7ff);
                c++;
                tr.push_back({1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'(r)});
                tm.push_back(11'h7ff);
                c++;
            end
        end
        tr.push_back(11'b110_0000_0000);
        tm.push_back(11'h7e0);
    endtask

    // one full permutation from IDLE, checked cycle by cycle, with stray start pulses that must be ignored
    task automatic run_perm(input bit m, input string name);
        build_trace(m);
        if (m) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
        foreach (tr[c]) begin
            ack = m ? ack_at(c) : 1'($urandom);
            if (m) start1 = 1'($urandom); else start0 = 1'($urandom);
            @(negedge clk);
            total_cnt++;
            if ((obs(m) & tm[c]) !== tr[c])
                $display("FAIL %s cycle %0d: got %b want %b", name, c, obs(m) & tm[c], tr[c]);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        start0 = 1'b0;
        start1 = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (obs(m) !== 11'd0 || obs(!m) !== 11'd0)
            $display("FAIL %s_idle: got %b/%b want all zero", name, obs(m), obs(!m));
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; ack = 1'b1; start0 = 1'b1; start1 = 1'b1;
        #3;
        total_cnt++;
        if (obs(0) !== 11'd0 || obs(1) !== 11'd0)
            $display("FAIL reset_async: got %b/%b want all zero", obs(0), obs(1));
        else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (obs(0) !== 11'd0 || obs(1) !== 11'd0)
            $display("FAIL reset_held: got %b/%b want all zero", obs(0), obs(1));
        else pass_cnt++;
`ifdef KECCAK_RND_SEQ_FSM_ERR_EN
        total_cnt++;
        if ({err0, err1} !== 2'b00) $display("FAIL reset_err: got %b want 00", {err0, err1});
        else pass_cnt++;
`endif
        start0 = 1'b0; start1 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_plain();
        ack_seq.delete();
        run_perm(0, "plain");
    endtask

    task automatic test_masked_ack1();
        ack_seq.delete();
        for (int i = 0; i < 200; i++) ack_seq.push_back(1'b1);
        run_perm(1, "masked_ack1");
    endtask

    task automatic test_masked_stall();
        ack_seq.delete();
        for (int i = 0; i < 200; i++) ack_seq.push_back(!(i >= 10 && i < 15));
        run_perm(1, "masked_stall");
    endtask

    task automatic test_masked_random();
        for (int k = 0; k < 3; k++) begin
            ack_seq.delete();
            for (int i = 0; i < 400; i++) ack_seq.push_back($urandom_range(0, 3) != 0);
            run_perm(1, "masked_random");
        end
    endtask

    task automatic test_clear();
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        total_cnt++;
        if (rnd0 !== 5'd10) $display("FAIL clear_pre: rnd got %0d want 10", rnd0);
        else pass_cnt++;
        @(posedge clk); #1;
        clear = 1'b1; start0 = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++;
            if (obs(0) !== 11'd0) $display("FAIL clear_idle %0d: got %b want all zero", i, obs(0));
            else pass_cnt++;
            @(posedge clk); #1;
            clear = 1'b0; start0 = 1'b0;
        end
        run_perm(0, "clear_rerun");
        ack = 1'b1; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        total_cnt++;
        if (rq1 !== 1'b1) $display("FAIL clear_ph2a_pre: rand_req got %b want 1", rq1);
        else pass_cnt++;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (obs(1) !== 11'd0) $display("FAIL clear_over_ack: got %b want all zero", obs(1));
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        ack_seq.delete();
        ack = 1'b1; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (14) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        total_cnt++;
        if (obs(1) !== {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4})
            $display("FAIL reset_mid_ph2b: got %b want 10110000100", obs(1));
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (obs(1) !== 11'd0 || obs(0) !== 11'd0)
            $display("FAIL reset_mid_async: got %b/%b want all zero", obs(1), obs(0));
        else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) ack_seq.push_back(1'b1);
        run_perm(1, "after_reset");
    endtask

    task automatic test_illegal();
        force u0.state_q = 6'h3f;
        #1;
        release u0.state_q;
        @(negedge clk);
        total_cnt++;
        if (obs(0) !== 11'd0) $display("FAIL illegal_outputs: got %b want all zero", obs(0));
        else pass_cnt++;
        @(posedge clk); #1;
`ifdef KECCAK_RND_SEQ_FSM_ERR_EN
        @(negedge clk);
        total_cnt++;
        if ({err0, obs(0)} !== {1'b1, 11'd0}) $display("FAIL err_set: got %b want 1 + zeros", {err0, obs(0)});
        else pass_cnt++;
        clear = 1'b1; start0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            total_cnt++;
            if ({err0, obs(0)} !== {1'b1, 11'd0}) $display("FAIL err_sticky %0d: got %b", i, {err0, obs(0)});
            else pass_cnt++;
        end
        clear = 1'b0; start0 = 1'b0;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (err0 !== 1'b0) $display("FAIL err_reset: got %b want 0", err0);
        else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
`endif
        ack_seq.delete();
        run_perm(0, "after_illegal");
    endtask

    initial begin
        test_reset();
        test_plain();
        test_masked_ack1();
        test_masked_stall();
        test_masked_random();
        test_clear();
        test_reset_mid();
        test_illegal();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
